// File: rtl/packetizer_pkg.sv
// packetizer_pkg
//   Shared definitions for the multi-channel packetizer:
//   - pkt_state_e : link FSM states (IDLE, HEADER, DATA)
//   - HDR_*_LSB   : bit offsets of the header word fields
//   - clog2       : ceiling log2 for elaboration-time width math
package packetizer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } pkt_state_e;

  // Header word layout: {zeros, channel, beat count}
  localparam int HDR_NBEATS_LSB = 0;
  localparam int HDR_CH_LSB     = 8;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/packetizer_mc_payload_fifo.sv
// payload_fifo
//   Synchronous first-word-fall-through FIFO holding whole payloads for one
//   channel. Occupancy is registered, so full_o/empty_o reflect the state at
//   the start of the cycle and never depend on this cycle's push or pop.
// Ports:
//   clk_payload  in   clock
//   reset        in   asynchronous, active-high
//   push_i       in   write data_i this edge (ignored while full)
//   data_i       in   WIDTH-bit payload
//   pop_i        in   drop the head entry this edge (ignored while empty)
//   head_o       out  oldest entry, valid whenever empty_o is 0
//   full_o       out  DEPTH entries held
//   empty_o      out  no entries held
module payload_fifo
  import packetizer_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int DEPTH = 2
) (
  input  logic             clk_payload,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_payload or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_payload) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/packetizer_mc.sv
// packetizer_mc
//   Buffers wide payloads from N_CH requesters in per-channel FIFOs,
//   round-robin arbitrates between them and serialises each payload onto a
//   shared link as one header word followed by N_BEATS data words (least
//   significant word first). Optional credit throttling caps the number of
//   transactions the L2 has not yet acknowledged.
// Ports:
//   clk_payload        in   sole clock
//   reset              in   asynchronous, active-high
//   payload_req_i      in   per-channel push request
//   payload_i          in   channel c at [c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
//   payload_grant_o    out  payload accepted this cycle
//   payload_full_o     out  channel FIFO full
//   packet_req_o       out  request for the link
//   lock_o             out  link held for the in-flight transaction
//   packet_o           out  link word
//   packet_grant_i     in   link grant
//   packet_received_i  in   one-cycle pulse: L2 consumed one transaction
//
// Handshakes: a payload transfers on any edge where payload_req_i[c] and
// payload_grant_o[c] are both high; the link is won on an edge where
// packet_req_o and packet_grant_i are both high, after which the header and
// all data words follow on consecutive cycles without further handshaking.
module packetizer_mc
  import packetizer_pkg::*;
#(
  parameter int PAYLOAD_WIDTH      = 512,
  parameter int PACKET_WIDTH       = 16,
  parameter int N_CH               = 2,
  parameter int DEPTH              = 2,
  parameter int THROTTLE_THRESHOLD = 2
) (
  input  logic                          clk_payload,
  input  logic                          reset,
  input  logic [N_CH-1:0]               payload_req_i,
  input  logic [N_CH*PAYLOAD_WIDTH-1:0] payload_i,
  output logic [N_CH-1:0]               payload_grant_o,
  output logic [N_CH-1:0]               payload_full_o,
  output logic                          packet_req_o,
  output logic                          lock_o,
  output logic [PACKET_WIDTH-1:0]       packet_o,
  input  logic                          packet_grant_i,
  input  logic                          packet_received_i
);

  localparam int N_BEATS = PAYLOAD_WIDTH / PACKET_WIDTH;
  localparam int CH_BITS = (clog2(N_CH) > 1) ? clog2(N_CH) : 1;
  localparam int OUT_W   = clog2(THROTTLE_THRESHOLD + 1) + 1;

  localparam logic [7:0]       LAST_BEAT = 8'(N_BEATS - 1);
  localparam logic [OUT_W-1:0] OUT_ONE   = OUT_W'(1);
  localparam logic [OUT_W-1:0] OUT_MAX   = '1;
  localparam logic [OUT_W-1:0] OUT_LIMIT = OUT_W'(THROTTLE_THRESHOLD);

  // Elaboration-time parameter sanity checks.
  if (PAYLOAD_WIDTH % PACKET_WIDTH != 0) begin : g_chk_div
    $error("packetizer_mc: PAYLOAD_WIDTH must be a multiple of PACKET_WIDTH");
  end
  if (PACKET_WIDTH < 8 + CH_BITS) begin : g_chk_hdr
    $error("packetizer_mc: PACKET_WIDTH too narrow for the header");
  end
  if (N_BEATS > 255) begin : g_chk_beats
    $error("packetizer_mc: N_BEATS must fit in 8 bits");
  end

  pkt_state_e                state_q, state_d;
  logic [CH_BITS-1:0]        sel_q, sel_d;
  logic [CH_BITS-1:0]        rr_q, rr_d;
  logic [7:0]                beat_q, beat_d;
  logic [OUT_W-1:0]          out_q, out_d;
  logic                      lock_q, lock_d;
  logic [PACKET_WIDTH-1:0]   packet_q, packet_d;

  logic [N_CH-1:0]           fifo_full;
  logic [N_CH-1:0]           fifo_empty;
  logic [N_CH-1:0]           fifo_pop;
  logic [N_CH-1:0]           eligible;
  logic [PAYLOAD_WIDTH-1:0]  head [N_CH];
  logic [PAYLOAD_WIDTH-1:0]  head_sel;
  logic                      credit_ok;
  logic                      issue;

  logic [2*N_CH-1:0]         elig_dbl;
  logic [N_CH-1:0]           elig_rot;
  logic                      arb_valid;
  int                        arb_off;
  logic [CH_BITS-1:0]        arb_sel;

  logic [7:0]                beat_nxt;
  logic [PAYLOAD_WIDTH-1:0]  data_shift;
  logic [PACKET_WIDTH-1:0]   data_word;
  logic [PACKET_WIDTH-1:0]   hdr_word;

  // ---------------------------------------------------------------- FIFOs
  // The grant is masked during reset so nothing is reported as accepted
  // while the FIFOs are being cleared.
  assign payload_grant_o = payload_req_i & ~fifo_full & {N_CH{~reset}};
  assign payload_full_o  = fifo_full;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    payload_fifo #(
      .WIDTH (PAYLOAD_WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_payload (clk_payload),
      .reset       (reset),
      .push_i      (payload_grant_o[c]),
      .data_i      (payload_i[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]),
      .pop_i       (fifo_pop[c]),
      .head_o      (head[c]),
      .full_o      (fifo_full[c]),
      .empty_o     (fifo_empty[c])
    );
    assign fifo_pop[c] = issue && (sel_q == CH_BITS'(c));
  end

  // ------------------------------------------------------------- arbiter
  assign credit_ok = (THROTTLE_THRESHOLD == 0) || (out_q < OUT_LIMIT);
  assign eligible  = ~fifo_empty & {N_CH{credit_ok}};

  // Rotate the eligible vector so rr_q sits at bit 0, then take the lowest
  // set bit; the winning channel is that offset from rr_q.
  always_comb begin
    elig_dbl  = {eligible, eligible};
    elig_rot  = N_CH'(elig_dbl >> rr_q);
    arb_valid = 1'b0;
    arb_off   = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (elig_rot[i]) begin
        arb_valid = 1'b1;
        arb_off   = i;
      end
    end
    arb_sel = CH_BITS'((int'(rr_q) + arb_off) % N_CH);
  end

  assign packet_req_o = (state_q == IDLE) && arb_valid;

  // ------------------------------------------------------ word formation
  // packet_q is registered, so each cycle loads the word for the NEXT cycle:
  // beat 0 when leaving HEADER, beat+1 while streaming DATA. The head entry
  // is stable for the whole transaction because it is only popped at the end.
  always_comb begin
    head_sel   = head[sel_q];
    beat_nxt   = (state_q == DATA) ? (beat_q + 8'd1) : 8'd0;
    data_shift = head_sel >> (int'(beat_nxt) * PACKET_WIDTH);
    data_word  = data_shift[PACKET_WIDTH-1:0];
    hdr_word   = '0;
    hdr_word[HDR_NBEATS_LSB +: 8]     = 8'(N_BEATS);
    hdr_word[HDR_CH_LSB +: CH_BITS]   = arb_sel;
  end

  // ------------------------------------------------------------ link FSM
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    beat_d   = beat_q;
    lock_d   = lock_q;
    packet_d = packet_q;
    issue    = 1'b0;
    case (state_q)
      IDLE: begin
        // A grant with no request is ignored.
        if (packet_req_o && packet_grant_i) begin
          state_d  = HEADER;
          sel_d    = arb_sel;
          lock_d   = 1'b1;
          packet_d = hdr_word;
        end
      end
      HEADER: begin
        state_d  = DATA;
        beat_d   = 8'd0;
        packet_d = data_word;
      end
      DATA: begin
        if (beat_q == LAST_BEAT) begin
          issue    = 1'b1;
          state_d  = IDLE;
          lock_d   = 1'b0;
          packet_d = '0;
          rr_d     = CH_BITS'((int'(sel_q) + 1) % N_CH);
        end else begin
          beat_d   = beat_nxt;
          packet_d = data_word;
        end
      end
      default: begin
        state_d  = IDLE;
        lock_d   = 1'b0;
        packet_d = '0;
      end
    endcase
  end

  // -------------------------------------------------- outstanding credits
  // Counts even with throttling disabled; saturates at both ends so a
  // spurious received pulse at zero is harmless.
  always_comb begin
    out_d = out_q;
    if (issue && !packet_received_i) begin
      if (out_q != OUT_MAX) out_d = out_q + OUT_ONE;
    end else if (!issue && packet_received_i) begin
      if (out_q != '0) out_d = out_q - OUT_ONE;
    end
  end

  always_ff @(posedge clk_payload or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_q     <= '0;
      beat_q   <= '0;
      out_q    <= '0;
      lock_q   <= 1'b0;
      packet_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_q     <= rr_d;
      beat_q   <= beat_d;
      out_q    <= out_d;
      lock_q   <= lock_d;
      packet_q <= packet_d;
    end
  end

  assign lock_o   = lock_q;
  assign packet_o = packet_q;

endmodule

// File: tb/tb_packetizer_mc.sv
// tb_packetizer_mc
//   Directed bench for packetizer_mc (2 channels, 64-bit payloads, 16-bit
//   link, depth 2, threshold 2). A transaction-level model (payload arrays,
//   a queue of pending link words, an outstanding count) predicts every
//   output each cycle; directed sections add literal expectations.
module tb_packetizer_mc;

  localparam int N_CH          = 2;
  localparam int PAYLOAD_WIDTH = 64;
  localparam int PACKET_WIDTH  = 16;
  localparam int DEPTH         = 2;
  localparam int THR           = 2;
  localparam int N_BEATS       = PAYLOAD_WIDTH / PACKET_WIDTH;
  localparam int OUT_MAX       = 7;  // 3-bit counter for threshold 2

  // ------------------------------------------------ clock / reset / DUT
  logic                          clk_payload = 1'b0;
  logic                          reset;
  logic [N_CH-1:0]               payload_req_i;
  logic [N_CH*PAYLOAD_WIDTH-1:0] payload_i;
  logic [N_CH-1:0]               payload_grant_o;
  logic [N_CH-1:0]               payload_full_o;
  logic                          packet_req_o;
  logic                          lock_o;
  logic [PACKET_WIDTH-1:0]       packet_o;
  logic                          packet_grant_i;
  logic                          packet_received_i;

  always #5 clk_payload = ~clk_payload;

  packetizer_mc #(
    .PAYLOAD_WIDTH      (PAYLOAD_WIDTH),
    .PACKET_WIDTH       (PACKET_WIDTH),
    .N_CH               (N_CH),
    .DEPTH              (DEPTH),
    .THROTTLE_THRESHOLD (THR)
  ) dut (
    .clk_payload       (clk_payload),
    .reset             (reset),
    .payload_req_i     (payload_req_i),
    .payload_i         (payload_i),
    .payload_grant_o   (payload_grant_o),
    .payload_full_o    (payload_full_o),
    .packet_req_o      (packet_req_o),
    .lock_o            (lock_o),
    .packet_o          (packet_o),
    .packet_grant_i    (packet_grant_i),
    .packet_received_i (packet_received_i)
  );

  // --------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Link words seen while lock_o is high, and the first word of each lock.
  logic [15:0] word_log[$];
  logic [15:0] hdr_log[$];
  logic        prev_lock = 1'b0;

  task automatic check_word(input string name, input int idx, input logic [15:0] exp);
    if (idx < word_log.size()) check(name, word_log[idx], exp);
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: word log holds %0d entries, expected index %0d = %0h", name, word_log.size(), idx, exp);
    end
  endtask

  task automatic check_hdr(input string name, input int idx, input logic [15:0] exp);
    if (idx < hdr_log.size()) check(name, hdr_log[idx], exp);
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: header log holds %0d entries, expected index %0d = %0h", name, hdr_log.size(), idx, exp);
    end
  endtask

  // ------------------------------------------------------------- model
  logic [63:0] m_fifo [N_CH][DEPTH];
  int          m_cnt  [N_CH];
  logic [15:0] m_words[$];
  int          m_sel;
  int          m_rr;
  int          m_out;

  // Runs on the falling edge: compare outputs against the model, then step
  // the model by the rising edge that follows, using the inputs now applied.
  always @(negedge clk_payload) begin
    logic [N_CH-1:0] e_grant, e_full;
    logic            e_req, e_lock, busy, credit, issue;
    logic [15:0]     e_pkt;
    int              sel, ch;

    credit = (THR == 0) || (m_out < THR);
    busy   = (m_words.size() > 0);
    e_req  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      e_full[c]  = (m_cnt[c] == DEPTH);
      e_grant[c] = payload_req_i[c] && !e_full[c] && !reset;
      if (!busy && credit && m_cnt[c] > 0) e_req = 1'b1;
    end
    e_lock = busy;
    e_pkt  = busy ? m_words[0] : 16'h0;
    if (reset) begin
      e_full = '0;
      e_req  = 1'b0;
      e_lock = 1'b0;
      e_pkt  = 16'h0;
    end

    check("grant", 64'(payload_grant_o), 64'(e_grant));
    check("full", 64'(payload_full_o), 64'(e_full));
    check("packet_req", 64'(packet_req_o), 64'(e_req));
    check("lock", 64'(lock_o), 64'(e_lock));
    check("packet", 64'(packet_o), 64'(e_pkt));

    if (lock_o) begin
      word_log.push_back(packet_o);
      if (!prev_lock) hdr_log.push_back(packet_o);
    end
    prev_lock = lock_o;

    if (reset) begin
      for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
      m_words.delete();
      m_sel = 0;
      m_rr  = 0;
      m_out = 0;
    end else begin
      issue = 1'b0;
      if (busy) begin
        void'(m_words.pop_front());
        if (m_words.size() == 0) begin
          issue = 1'b1;
          for (int i = 0; i < DEPTH - 1; i++) m_fifo[m_sel][i] = m_fifo[m_sel][i+1];
          m_cnt[m_sel]--;
          m_rr = (m_sel + 1) % N_CH;
        end
      end else if (e_req && packet_grant_i) begin
        sel = -1;
        for (int k = 0; k < N_CH; k++) begin
          ch = (m_rr + k) % N_CH;
          if (sel < 0 && m_cnt[ch] > 0) sel = ch;
        end
        m_sel = sel;
        m_words.push_back(16'(sel * 256 + N_BEATS));
        for (int b = 0; b < N_BEATS; b++)
          m_words.push_back(16'(m_fifo[sel][0] >> (16 * b)));
      end
      for (int c = 0; c < N_CH; c++) begin
        if (e_grant[c]) begin
          m_fifo[c][m_cnt[c]] = payload_i[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
          m_cnt[c]++;
        end
      end
      if (issue && !packet_received_i) m_out = (m_out < OUT_MAX) ? m_out + 1 : OUT_MAX;
      else if (!issue && packet_received_i && m_out > 0) m_out--;
    end
  end

  // ------------------------------------------------------- driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_payload);
    #1;
  endtask

  task automatic do_reset();
    payload_req_i     = '0;
    packet_grant_i    = 1'b0;
    packet_received_i = 1'b0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    word_log.delete();
    hdr_log.delete();
  endtask

  task automatic push(input int c, input logic [63:0] d);
    payload_req_i[c] = 1'b1;
    payload_i[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = d;
    cyc(1);
    payload_req_i[c] = 1'b0;
  endtask

  task automatic push_g(input int c, input logic [63:0] d, output logic g);
    payload_req_i[c] = 1'b1;
    payload_i[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = d;
    @(negedge clk_payload);
    g = payload_grant_o[c];
    cyc(1);
    payload_req_i[c] = 1'b0;
  endtask

  task automatic pulse_rcv();
    packet_received_i = 1'b1;
    cyc(1);
    packet_received_i = 1'b0;
  endtask

  task automatic push_both(input logic [63:0] d0, input logic [63:0] d1);
    payload_req_i = '1;
    payload_i[0 +: PAYLOAD_WIDTH]             = d0;
    payload_i[PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = d1;
    cyc(1);
    payload_req_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    logic g;
    int   n;
    logic found;

    reset             = 1'b1;
    payload_req_i     = '0;
    payload_i         = '0;
    packet_grant_i    = 1'b0;
    packet_received_i = 1'b0;
    cyc(2);
    check("reset_req", 64'(packet_req_o), 64'(0));
    check("reset_packet", 64'(packet_o), 64'(0));
    reset = 1'b0;

    // Single payload on channel 1, link granted at once.
    do_reset();
    packet_grant_i = 1'b1;
    push(1, 64'h0004_0003_0002_0001);
    cyc(7);
    check("t1_lock_cycles", word_log.size(), 5);
    check_word("t1_w0", 0, 16'h0104);
    check_word("t1_w1", 1, 16'h0001);
    check_word("t1_w2", 2, 16'h0002);
    check_word("t1_w3", 3, 16'h0003);
    check_word("t1_w4", 4, 16'h0004);

    // Both channels loaded: channel 0 first, then channel 1; pointer wraps.
    do_reset();
    push_both(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
    packet_grant_i = 1'b1;
    cyc(14);
    check_hdr("t2_hdr0", 0, 16'h0004);
    check_hdr("t2_hdr1", 1, 16'h0104);
    check_word("t2_ch0_w0", 1, 16'h4444);
    check_word("t2_ch1_w3", 9, 16'h5555);
    pulse_rcv();
    pulse_rcv();
    packet_grant_i = 1'b0;
    push_both(64'h0a0a_0b0b_0c0c_0d0d, 64'h0e0e_0f0f_1010_1212);
    packet_grant_i = 1'b1;
    cyc(14);
    check_hdr("t2_rr_hdr2", 2, 16'h0004);
    check_hdr("t2_rr_hdr3", 3, 16'h0104);

    // Throttle: three payloads, only two go out until a credit returns.
    do_reset();
    push_both(64'h0000_0000_0000_00a1, 64'h0000_0000_0000_00b1);
    push(0, 64'h0000_0000_0000_00a2);
    packet_grant_i = 1'b1;
    cyc(20);
    check("t3_two_sent", hdr_log.size(), 2);
    check("t3_req_blocked", 64'(packet_req_o), 64'(0));
    pulse_rcv();
    check("t3_req_restored", 64'(packet_req_o), 64'(1));
    cyc(7);
    check("t3_three_sent", hdr_log.size(), 3);
    check_hdr("t3_hdr2", 2, 16'h0004);

    // Depth 2: third push refused until the head is popped.
    do_reset();
    push_g(0, 64'hd1d1_d1d1_d1d1_d1d1, g);
    check("t4_g1", 64'(g), 64'(1));
    push_g(0, 64'hd2d2_d2d2_d2d2_d2d2, g);
    check("t4_g2", 64'(g), 64'(1));
    payload_req_i[0] = 1'b1;
    payload_i[0 +: PAYLOAD_WIDTH] = 64'hd3d3_d3d3_d3d3_d3d3;
    @(negedge clk_payload);
    check("t4_g3", 64'(payload_grant_o[0]), 64'(0));
    check("t4_full", 64'(payload_full_o[0]), 64'(1));
    cyc(1);
    packet_grant_i = 1'b1;
    n = 0;
    found = 1'b0;
    while (n < 20 && !found) begin
      @(negedge clk_payload);
      if (payload_grant_o[0]) found = 1'b1;
      else n++;
    end
    check("t4_wait_cycles", n, 6);
    cyc(1);
    payload_req_i[0] = 1'b0;
    cyc(14);
    check_word("t4_d2_w0", 6, 16'hd2d2);

    // Simultaneous issue and received keeps outstanding at 1.
    do_reset();
    packet_grant_i = 1'b1;
    push(0, 64'h0000_0000_0000_0e01);
    cyc(7);
    push(0, 64'h0000_0000_0000_0e02);
    push(0, 64'h0000_0000_0000_0e03);
    cyc(4);
    packet_received_i = 1'b1;
    cyc(1);
    packet_received_i = 1'b0;
    cyc(8);
    push(0, 64'h0000_0000_0000_0e04);
    cyc(10);
    check("t5_three_sent", hdr_log.size(), 3);
    check("t5_req_blocked", 64'(packet_req_o), 64'(0));

    // Spurious received at zero does not create credit.
    do_reset();
    pulse_rcv();
    packet_grant_i = 1'b1;
    push_both(64'h0000_0000_0000_0f01, 64'h0000_0000_0000_0f02);
    push(0, 64'h0000_0000_0000_0f03);
    cyc(25);
    check("t5_spurious_two_sent", hdr_log.size(), 2);
    check("t5_spurious_req", 64'(packet_req_o), 64'(0));

    // Reset during DATA beat 2.
    do_reset();
    packet_grant_i = 1'b1;
    push(1, 64'h0004_0003_0002_0001);
    cyc(4);
    check("t6_beat2", 64'(packet_o), 64'h0003);
    reset = 1'b1;
    #1;
    check("t6_rst_packet", 64'(packet_o), 64'(0));
    check("t6_rst_lock", 64'(lock_o), 64'(0));
    check("t6_rst_req", 64'(packet_req_o), 64'(0));
    cyc(1);
    reset = 1'b0;
    cyc(5);
    check("t6_post_req", 64'(packet_req_o), 64'(0));
    check("t6_post_full", 64'(payload_full_o), 64'(0));
    check("t6_post_lock", 64'(lock_o), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
